// File: rtl/mips_prog_loader_pkg.sv
// rtl/mips_prog_loader_pkg.sv - shared constants and FSM encoding for the MIPS program loader
package mips_prog_loader_pkg;

    localparam int WORD_W        = 32;
    localparam int ADDR_W        = 10;
    localparam int DEF_MEM_WORDS = 1024;
    localparam logic [5:0] HALT_OP = 6'h3f;

`ifdef MIPS_LOADER_CSUM_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        CSUM   = 3'd4,
        DONE   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_HI = 3'd1,
        LEN_LO = 3'd2,
        DATA   = 3'd3,
        DONE   = 3'd5
    } state_t;
`endif

endpackage

// File: rtl/mips_word_assembler.sv
// rtl/mips_word_assembler.sv - big-endian byte-to-word shifter with word-complete flag
module mips_word_assembler
    import mips_prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              byte_en,
    input  logic [7:0]        byte_data,
    output logic [WORD_W-1:0] word,
    output logic              word_full
);

    logic [23:0] shift;
    logic [1:0]  byte_idx;

    // The 4th byte is merged combinationally so the word is ready on its accepting edge.
    assign word      = {shift, byte_data};
    assign word_full = byte_en && (byte_idx == 2'd3);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift    <= '0;
            byte_idx <= '0;
        end else if (clr) begin
            shift    <= '0;
            byte_idx <= '0;
        end else if (byte_en) begin
            shift    <= {shift[15:0], byte_data};
            byte_idx <= byte_idx + 2'd1;
        end
    end

endmodule

// File: rtl/mips_prog_loader.sv
// rtl/mips_prog_loader.sv - byte-stream instruction-memory loader; optional checksum via MIPS_LOADER_CSUM_EN
module mips_prog_loader
    import mips_prog_loader_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              busy,
    output logic              cpu_go,
    output logic              err
);

    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [31:0]       LIMIT = 32'(MEM_WORDS - BASE_ADDR);

    state_t            state, state_next;
    logic [15:0]       len, word_cnt, len_next;
    logic              accept, len_bad, last_done, set_err, byte_en, word_full;
    logic [WORD_W-1:0] word;
`ifdef MIPS_LOADER_CSUM_EN
    logic [7:0]        csum;
`endif

    assign accept    = in_valid && in_ready;
    assign len_next  = {len[15:8], in_data};
    assign len_bad   = (len_next == 16'd0) || ({16'd0, len_next} > LIMIT);
    assign last_done = mem_we && (word_cnt == len);
    assign byte_en   = accept && (state == DATA);

    mips_word_assembler u_asm (
        .clk       (clk1),
        .rst_n     (rst_n),
        .clr       (state == IDLE),
        .byte_en   (byte_en),
        .byte_data (in_data),
        .word      (word),
        .word_full (word_full)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        cpu_go     = 1'b0;
        set_err    = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_next = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (accept) state_next = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (len_bad) begin
                        set_err    = 1'b1;
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                // Stop taking bytes once the final word is captured, so a trailing byte is left for CSUM.
                in_ready = (word_cnt != len);
`ifdef MIPS_LOADER_CSUM_EN
                if (last_done) state_next = CSUM;
`else
                if (last_done) state_next = DONE;
`endif
            end
`ifdef MIPS_LOADER_CSUM_EN
            CSUM: begin
                in_ready = 1'b1;
                if (accept) begin
                    if (in_data == csum) begin
                        state_next = DONE;
                    end else begin
                        set_err    = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
`endif
            DONE: begin
                cpu_go     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            len       <= '0;
            word_cnt  <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
        end else begin
            mem_we <= word_full;
            if (state == IDLE && start) err <= 1'b0;
            else if (set_err)           err <= 1'b1;
            if (state == IDLE) word_cnt <= '0;
            if (state == LEN_HI && accept) len[15:8] <= in_data;
            if (state == LEN_LO && accept) len[7:0]  <= in_data;
            if (word_full) begin
                mem_wdata <= word;
                mem_addr  <= BASE + word_cnt[ADDR_W-1:0];
                word_cnt  <= word_cnt + 16'd1;
            end
        end
    end

`ifdef MIPS_LOADER_CSUM_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n)             csum <= '0;
        else if (state == IDLE) csum <= '0;
        else if (byte_en)       csum <= csum ^ in_data;
    end
`endif

endmodule

// File: tb/tb_mips_prog_loader.sv
// tb/tb_mips_prog_loader.sv - table-driven self-checking bench for mips_prog_loader
module tb_mips_prog_loader;

    logic        clk1 = 1'b0;
    logic        rst_n, start, in_valid;
    logic [7:0]  in_data;
    logic        in_ready, mem_we, busy, cpu_go, err;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [9:0]  qa[$];
    logic [31:0] qd[$];
    int          qc[$];
    int          go_n, go_cyc;

    mips_prog_loader #(.BASE_ADDR(0), .MEM_WORDS(1024)) dut (
        .clk1      (clk1),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cpu_go    (cpu_go),
        .err       (err)
    );

    always #5 clk1 = ~clk1;
    always @(posedge clk1) cyc <= cyc + 1;

    always @(negedge clk1) begin
        if (mem_we) begin
            qa.push_back(mem_addr);
            qd.push_back(mem_wdata);
            qc.push_back(cyc);
        end
        if (cpu_go) begin
            go_n++;
            go_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: act=0x%0h req=0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_sb();
        qa.delete(); qd.delete(); qc.delete();
        go_n = 0; go_cyc = -1;
    endtask

    task automatic pulse_start();
        @(negedge clk1); start = 1'b1;
        @(negedge clk1); start = 1'b0;
    endtask

    // Entered and left on a falling edge; in_valid stays high after an accepted byte.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk1);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk1);
            n++;
        end
        if (!in_ready) check("send_timeout", 32'd1, 32'd0);
        @(negedge clk1);
    endtask

    typedef struct {
        logic [7:0]  b[12];
        int          n;
        int          gap;
        int          nw;
        logic [9:0]  wa[2];
        logic [31:0] wd[2];
        logic        go;
        logic        er;
    } vec_t;

    vec_t tv[5];

    task automatic send_stream(input vec_t v, input bit add_cs);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < v.n; i++) begin
            send_byte(v.b[i], v.gap);
            if (i >= 2) x = x ^ v.b[i];
        end
`ifdef MIPS_LOADER_CSUM_EN
        if (add_cs) send_byte(x, v.gap);
`else
        if (add_cs) x = 8'h00;
`endif
        in_valid = 1'b0;
    endtask

    task automatic check_result(input string tag, input vec_t v);
        check({tag, "_nw"}, qa.size(), v.nw);
        for (int k = 0; k < v.nw && k < qa.size(); k++) begin
            check({tag, "_addr"}, qa[k], v.wa[k]);
            check({tag, "_data"}, qd[k], v.wd[k]);
        end
        check({tag, "_go"}, go_n, v.go ? 1 : 0);
        if (v.go && qc.size() > 0) check({tag, "_go_cyc"}, go_cyc, qc[qc.size()-1] + 1);
        check({tag, "_err"}, err, v.er);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;

        tv[0].b = '{8'h00,8'h02,8'h28,8'h01,8'h00,8'h78,8'hFC,8'h00,8'h00,8'h00,8'h00,8'h00};
        tv[0].n = 10; tv[0].gap = 0; tv[0].nw = 2;
        tv[0].wa = '{10'd0, 10'd1}; tv[0].wd = '{32'h28010078, 32'hFC000000};
        tv[0].go = 1'b1; tv[0].er = 1'b0;
        tv[1] = tv[0]; tv[1].gap = 3;
        tv[2] = tv[0]; tv[2].b[0] = 8'h00; tv[2].b[1] = 8'h00; tv[2].n = 2;
        tv[2].nw = 0; tv[2].go = 1'b0; tv[2].er = 1'b1;
        tv[3] = tv[2]; tv[3].b[0] = 8'h04; tv[3].b[1] = 8'h01;
        tv[4] = tv[0]; tv[4].b[1] = 8'h01; tv[4].b[2] = 8'hDE; tv[4].b[3] = 8'hAD;
        tv[4].b[4] = 8'hBE; tv[4].b[5] = 8'hEF; tv[4].n = 6; tv[4].gap = 1; tv[4].nw = 1;
        tv[4].wd[0] = 32'hDEADBEEF;

        repeat (2) @(negedge clk1);
        check("rst_ready", in_ready, 0);
        check("rst_we", mem_we, 0);
        check("rst_busy", busy, 0);
        check("rst_go", cpu_go, 0);
        check("rst_err", err, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        rst_n = 1'b1;

        for (int t = 0; t < 5; t++) begin
            clear_sb();
            pulse_start();
            check($sformatf("v%0d_err_clr", t), err, 0);
            check($sformatf("v%0d_busy_on", t), busy, 1);
            send_stream(tv[t], !tv[t].er);
            if (tv[t].er) check($sformatf("v%0d_busy_fast", t), busy, 0);
            repeat (8) @(negedge clk1);
            check_result($sformatf("v%0d", t), tv[t]);
        end

        // Start asserted mid-load must not disturb the transfer.
        clear_sb();
        pulse_start();
        for (int i = 0; i < 10; i++) begin
            send_byte(tv[0].b[i], 0);
            if (i == 4) start = 1'b1;
            if (i == 5) start = 1'b0;
        end
`ifdef MIPS_LOADER_CSUM_EN
        send_byte(8'hAD, 0);
`endif
        in_valid = 1'b0;
        start    = 1'b0;
        repeat (8) @(negedge clk1);
        check_result("midstart", tv[0]);

`ifdef MIPS_LOADER_CSUM_EN
        clear_sb();
        pulse_start();
        send_stream(tv[0], 1'b0);
        send_byte(8'h00, 0);
        in_valid = 1'b0;
        repeat (8) @(negedge clk1);
        v = tv[0]; v.go = 1'b0; v.er = 1'b1;
        check_result("csum_bad", v);
`endif

        // Reset after 6 data bytes of a 2-word load.
        clear_sb();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(tv[0].b[i], 0);
        in_valid = 1'b0;
        repeat (2) @(negedge clk1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_ready", in_ready, 0);
        check("abort_we", mem_we, 0);
        check("abort_busy", busy, 0);
        check("abort_go", cpu_go, 0);
        check("abort_err", err, 0);
        check("abort_addr", mem_addr, 0);
        check("abort_wdata", mem_wdata, 0);
        repeat (2) @(negedge clk1);
        rst_n = 1'b1;
        repeat (10) @(negedge clk1);
        v = tv[0]; v.nw = 1; v.go = 1'b0;
        check_result("abort", v);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
